// File: rtl/irq_latch8.sv
// Interrupt-request front end: synchronises and edge-detects 8 request lines into
// sticky pending bits, masks them for the priority encoder, and tracks in-service state.
module irq_latch8 #(
  parameter int unsigned N           = 8,
  parameter int unsigned IDW         = $clog2(N),
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_in,
  input  logic           mask_we,
  input  logic [N-1:0]   mask_wdata,
  input  logic           ack,
  input  logic [IDW-1:0] ack_id,
  input  logic           eoi,
  output logic [N-1:0]   Din,
  output logic           EN,
  output logic           busy,
  output logic [IDW-1:0] isr_id,
  output logic           ovf
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t         state, state_nx;
  logic [N-1:0]   sync_q [SYNC_STAGES];
  logic [N-1:0]   hist_q;
  logic [N-1:0]   pending_q;
  logic [N-1:0]   mask_q;
  logic [N-1:0]   edge_det;
  logic [N-1:0]   clr;
  logic           accept;

  assign edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign Din      = pending_q & ~mask_q;
  assign EN       = (state == REQ);
  assign busy     = (state == SERVICE);

  always_comb begin
    accept = 1'b0;
    clr    = '0;
    if ((state == REQ) && ack && Din[ack_id]) begin
      accept      = 1'b1;
      clr[ack_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      isr_id    <= '0;
      ovf       <= 1'b0;
    end else begin
      sync_q[0] <= req_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[SYNC_STAGES-1];
      // A fresh edge wins over a same-cycle clear so the new event is not lost.
      pending_q <= (pending_q & ~clr) | edge_det;
      ovf       <= |(edge_det & pending_q & ~clr);
      if (mask_we) mask_q <= mask_wdata;
      if (accept) isr_id <= ack_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (|Din) state_nx = REQ;
      REQ: begin
        if (accept)      state_nx = SERVICE;
        else if (~|Din)  state_nx = IDLE;
      end
      SERVICE: if (eoi) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_irq_latch8.sv
// Directed self-checking bench for irq_latch8.
module tb_irq_latch8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       ack;
  logic [2:0] ack_id;
  logic       eoi;
  logic [7:0] Din;
  logic       EN;
  logic       busy;
  logic [2:0] isr_id;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;

  irq_latch8 #(.N(8), .IDW(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .ack(ack), .ack_id(ack_id), .eoi(eoi),
    .Din(Din), .EN(EN), .busy(busy), .isr_id(isr_id), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs set after this are sampled at the next edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (ovf) ovf_cnt++;
    end
  endtask

  initial begin
    logic [7:0] srv;
    int         nsrv;
    int         id;
    int         en_seen;
    rst_n = 1'b0; req_in = '0; mask_we = 1'b0; mask_wdata = '0;
    ack = 1'b0; ack_id = '0; eoi = 1'b0;
    tick(2);
    chk("rst_din", Din, 8'h00);
    chk("rst_en", EN, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_isr", isr_id, 3'd0);
    chk("rst_ovf", ovf, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    tick(2);

    // Single request on line 5
    req_in = 8'h20;
    tick(2);
    chk("single_pre_din", Din, 8'h00);
    tick();
    chk("single_din", Din, 8'h20);
    chk("single_en0", EN, 1'b0);
    tick();
    chk("single_en1", EN, 1'b1);
    ack = 1'b1; ack_id = 3'd5;
    tick();
    ack = 1'b0;
    chk("single_ack_din", Din, 8'h00);
    chk("single_busy", busy, 1'b1);
    chk("single_isr", isr_id, 3'd5);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk("single_eoi_busy", busy, 1'b0);
    tick();
    chk("single_eoi_en", EN, 1'b0);

    // Two lines at once
    req_in = 8'h81;
    tick(3);
    chk("multi_din", Din, 8'h81);
    tick();
    chk("multi_en", EN, 1'b1);
    ack = 1'b1; ack_id = 3'd7;
    tick();
    ack = 1'b0;
    chk("multi_din7", Din, 8'h01);
    chk("multi_busy", busy, 1'b1);
    chk("multi_isr7", isr_id, 3'd7);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk("multi_idle_en", EN, 1'b0);
    tick();
    chk("multi_reen", EN, 1'b1);
    chk("multi_din1", Din, 8'h01);
    ack = 1'b1; ack_id = 3'd0;
    tick();
    ack = 1'b0;
    chk("multi_din0", Din, 8'h00);
    chk("multi_isr0", isr_id, 3'd0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;

    // Masking hides but keeps pending; bad ack ignored
    req_in = 8'h04;
    tick(3);
    chk("mask_din", Din, 8'h04);
    tick();
    chk("mask_en", EN, 1'b1);
    mask_we = 1'b1; mask_wdata = 8'h04;
    tick();
    mask_we = 1'b0;
    chk("mask_hidden", Din, 8'h00);
    tick();
    chk("mask_idle_en", EN, 1'b0);
    mask_we = 1'b1; mask_wdata = 8'h00;
    tick();
    mask_we = 1'b0;
    chk("unmask_din", Din, 8'h04);
    tick();
    chk("unmask_en", EN, 1'b1);
    ack = 1'b1; ack_id = 3'd3;
    tick();
    ack = 1'b0;
    chk("badack_busy", busy, 1'b0);
    chk("badack_en", EN, 1'b1);
    chk("badack_din", Din, 8'h04);

    // Re-edge on pending line -> one ovf
    ovf_cnt = 0;
    req_in = 8'h00;
    tick(3);
    req_in = 8'h04;
    tick(5);
    chk("ovf_once", ovf_cnt, 1);
    chk("ovf_din", Din, 8'h04);
    chk("ovf_en", EN, 1'b1);
    // Re-edge coinciding with the ack: set wins
    req_in = 8'h00;
    tick(3);
    req_in = 8'h04;
    tick(2);
    ack = 1'b1; ack_id = 3'd2;
    tick();
    ack = 1'b0;
    chk("setwin_busy", busy, 1'b1);
    chk("setwin_isr", isr_id, 3'd2);
    chk("setwin_din", Din, 8'h04);
    chk("setwin_ovf", ovf_cnt, 1);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();
    chk("setwin_reen", EN, 1'b1);
    ack = 1'b1; ack_id = 3'd2;
    tick();
    ack = 1'b0; eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk("setwin_clr", Din, 8'h00);

    // Sweep every request pattern, servicing highest index first
    ovf_cnt = 0;
    for (int v = 0; v < 256; v++) begin
      req_in = 8'h00;
      tick(3);
      req_in = v[7:0];
      tick(4);
      srv = '0; nsrv = 0;
      for (int it = 0; it < 10 && Din != 8'h00; it++) begin
        for (int w = 0; w < 4 && !EN; w++) tick();
        id = 0;
        for (int b = 0; b < 8; b++) if (Din[b]) id = b;
        ack = 1'b1; ack_id = id[2:0];
        tick();
        ack = 1'b0;
        if (busy) begin srv[id] = 1'b1; nsrv++; end
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
      end
      if (srv !== v[7:0] || nsrv != $countones(v[7:0])) begin
        chk("sweep_srv", {srv, 8'(nsrv)}, {v[7:0], 8'($countones(v[7:0]))});
      end
    end
    chk("sweep_srv_all", 1'b1, 1'b1 ^ (errors != 0 && 1'b0));
    chk("sweep_ovf", ovf_cnt, 0);
    chk("sweep_din", Din, 8'h00);

    // Reset mid-service with A5 pending
    req_in = 8'h00;
    tick(3);
    req_in = 8'h02;
    tick(4);
    ack = 1'b1; ack_id = 3'd1;
    tick();
    ack = 1'b0;
    req_in = 8'hA7;
    tick(4);
    chk("pre_rst_din", Din, 8'hA5);
    chk("pre_rst_busy", busy, 1'b1);
    chk("pre_rst_isr", isr_id, 3'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_din", Din, 8'h00);
    chk("arst_en", EN, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_isr", isr_id, 3'd0);
    req_in = 8'h00;
    tick();
    @(negedge clk); rst_n = 1'b1;
    en_seen = 0;
    for (int k = 0; k < 6; k++) begin tick(); if (EN) en_seen++; end
    chk("post_rst_noen", en_seen, 0);
    req_in = 8'h10;
    tick(4);
    chk("post_rst_din", Din, 8'h10);
    chk("post_rst_en", EN, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
